// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding encodings,
// FSM states and the shadow-stage records tracked for EX, MEM and WB.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } stage_t;

  typedef struct packed {
    stage_t           ctl;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } ex_stage_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             ex_branch_taken;
  logic             mem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pc_sel_branch;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_mem_write, ex_branch_taken, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           pc_sel_branch, fwd_a, fwd_b, stall_cnt, flush_cnt, mem_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_mem_write, ex_branch_taken, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           pc_sel_branch, fwd_a, fwd_b, stall_cnt, flush_cnt, mem_err
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding select for one ALU operand; the younger MEM producer beats WB.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_wr,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       sel_c
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired zero, so it never takes a forwarded value
  assign mem_hit = mem_wr && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = wb_wr  && (wb_rd  != '0) && (wb_rd  == src);

  always_comb begin
    sel_c = FWD_RF;
    if (mem_hit) begin
      sel_c = FWD_EXMEM;
    end else if (wb_hit) begin
      sel_c = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stalls, flushes,
// forwarding selects, memory-wait freeze with timeout, and perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  ex_stage_t   ex_q, id_entry;
  stage_t      mem_q, wb_q;
  ctrl_state_e state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic       freeze_c, branch_flush_c, load_use_c, rs1_hit_c, rs2_hit_c;
  logic [4:0] en_c;
  logic       ifid_flush_c, idex_flush_c, pc_sel_c;
  logic [1:0] fwd_a_c, fwd_b_c;
  logic       unused_wb_mem;

  assign freeze_c       = mem_q.valid & (mem_q.mem_read | mem_q.mem_write) & ~bus.mem_ready;
  assign branch_flush_c = bus.ex_branch_taken & ex_q.ctl.valid & ~freeze_c;
  assign rs1_hit_c      = bus.id_use_rs1 & (bus.id_rs1 == ex_q.ctl.rd);
  assign rs2_hit_c      = bus.id_use_rs2 & (bus.id_rs2 == ex_q.ctl.rd);
  assign load_use_c     = ~freeze_c & ~branch_flush_c & ex_q.ctl.valid & ex_q.ctl.mem_read &
                          (ex_q.ctl.rd != '0) & bus.id_valid & (rs1_hit_c | rs2_hit_c);

  // Enables ordered {pc, ifid, idex, exmem, memwb}; priority freeze > branch > load-use
  always_comb begin
    en_c         = 5'b11111;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    pc_sel_c     = 1'b0;
    if (freeze_c) begin
      en_c = 5'b00000;
    end else if (branch_flush_c) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      pc_sel_c     = 1'b1;
    end else if (load_use_c) begin
      en_c         = 5'b00111;
      idex_flush_c = 1'b1;
    end
  end

  always_comb begin
    id_entry               = '0;
    id_entry.ctl.valid     = bus.id_valid;
    id_entry.ctl.rd        = bus.id_rd;
    id_entry.ctl.reg_write = bus.id_reg_write;
    id_entry.ctl.mem_read  = bus.id_mem_read;
    id_entry.ctl.mem_write = bus.id_mem_write;
    id_entry.rs1           = bus.id_rs1;
    id_entry.rs2           = bus.id_rs2;
  end

  // Shadow pipeline advances in lockstep with the real one; frozen during memory wait
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze_c) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.ctl;
      ex_q  <= idex_flush_c ? '0 : id_entry;
    end
  end

  assign unused_wb_mem = wb_q.mem_read | wb_q.mem_write;

  fwd_select u_fwd_a (
    .src    (ex_q.rs1),
    .mem_wr (mem_q.valid & mem_q.reg_write),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid & wb_q.reg_write),
    .wb_rd  (wb_q.rd),
    .sel_c  (fwd_a_c)
  );

  fwd_select u_fwd_b (
    .src    (ex_q.rs2),
    .mem_wr (mem_q.valid & mem_q.reg_write),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid & wb_q.reg_write),
    .wb_rd  (wb_q.rd),
    .sel_c  (fwd_b_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Wait counter includes the cycle the freeze is first seen in RUN
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      ST_RUN: begin
        if (freeze_c) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if ((state_d == ST_MEM_WAIT) && (wait_d == WAIT_MAX)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((freeze_c || load_use_c) && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (branch_flush_c && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign bus.pc_en         = en_c[4];
  assign bus.ifid_en       = en_c[3];
  assign bus.idex_en       = en_c[2];
  assign bus.exmem_en      = en_c[1];
  assign bus.memwb_en      = en_c[0];
  assign bus.ifid_flush    = ifid_flush_c;
  assign bus.idex_flush    = idex_flush_c;
  assign bus.pc_sel_branch = pc_sel_c;
  assign bus.fwd_a         = fwd_a_c;
  assign bus.fwd_b         = fwd_b_c;
  assign bus.stall_cnt     = stall_q;
  assign bus.flush_cnt     = flush_q;
  assign bus.mem_err       = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run checked against an instruction-level pipeline model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction-level model: each stage holds the instruction currently in it
  typedef struct {
    bit valid; int rd; bit wr; bit ld; bit st; int rs1; int rs2;
  } instr_t;
  typedef enum {K_RUN, K_FREEZE, K_BRANCH, K_LOADUSE} kind_e;

  instr_t m_ex, m_mem, m_wb;
  longint m_stall, m_flush;
  int     m_wait_run;
  bit     m_err;
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic instr_t nop();
    instr_t t;
    t = '{valid: 0, rd: 0, wr: 0, ld: 0, st: 0, rs1: 0, rs2: 0};
    return t;
  endfunction

  function automatic instr_t id_instr();
    instr_t t;
    t.valid = bus.id_valid;
    t.rd    = int'(bus.id_rd);
    t.wr    = bus.id_reg_write;
    t.ld    = bus.id_mem_read;
    t.st    = bus.id_mem_write;
    t.rs1   = int'(bus.id_rs1);
    t.rs2   = int'(bus.id_rs2);
    return t;
  endfunction

  function automatic kind_e classify();
    bit hit;
    if (m_mem.valid && (m_mem.ld || m_mem.st) && !bus.mem_ready) return K_FREEZE;
    if (bus.ex_branch_taken && m_ex.valid) return K_BRANCH;
    hit = (bus.id_use_rs1 && int'(bus.id_rs1) == m_ex.rd) ||
          (bus.id_use_rs2 && int'(bus.id_rs2) == m_ex.rd);
    if (m_ex.valid && m_ex.ld && m_ex.rd != 0 && bus.id_valid && hit) return K_LOADUSE;
    return K_RUN;
  endfunction

  // Most recent older producer of register r wins; x0 is never forwarded
  function automatic logic [1:0] fwd_for(int r);
    if (r == 0) return 2'b00;
    if (m_mem.valid && m_mem.wr && m_mem.rd == r) return 2'b10;
    if (m_wb.valid && m_wb.wr && m_wb.rd == r) return 2'b01;
    return 2'b00;
  endfunction

  // {pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush, pc_sel, fwd_a, fwd_b}
  function automatic logic [11:0] exp_ctrl();
    logic [4:0] en;
    logic [2:0] fl;
    case (classify())
      K_FREEZE:  begin en = 5'b00000; fl = 3'b000; end
      K_BRANCH:  begin en = 5'b11111; fl = 3'b111; end
      K_LOADUSE: begin en = 5'b00111; fl = 3'b010; end
      default:   begin en = 5'b11111; fl = 3'b000; end
    endcase
    return {en, fl, fwd_for(m_ex.rs1), fwd_for(m_ex.rs2)};
  endfunction

  function automatic logic [11:0] dut_ctrl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.pc_sel_branch, bus.fwd_a, bus.fwd_b};
  endfunction

  task automatic model_reset();
    m_ex = nop(); m_mem = nop(); m_wb = nop();
    m_stall = 0; m_flush = 0; m_wait_run = 0; m_err = 0;
  endtask

  task automatic model_step();
    kind_e k;
    k = classify();
    if (k != K_FREEZE) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (k == K_BRANCH || k == K_LOADUSE) ? nop() : id_instr();
    end
    if ((k == K_FREEZE || k == K_LOADUSE) && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (k == K_BRANCH && m_flush < 64'hFFFF_FFFF) m_flush++;
    m_wait_run = (k == K_FREEZE) ? m_wait_run + 1 : 0;
    if (m_wait_run >= int'(MEM_TIMEOUT)) m_err = 1;
  endtask

  // Called at a falling edge with inputs stable; returns at the next falling edge
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.ex_branch_taken = 0; bus.mem_ready = 1;
  endtask

  task automatic set_id(input bit v, input int rd, input int rs1, input int rs2,
                        input bit u1, input bit u2, input bit rw, input bit mr, input bit mw);
    bus.id_valid = v; bus.id_rd = 5'(rd); bus.id_rs1 = 5'(rs1); bus.id_rs2 = 5'(rs2);
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
  endtask

  task automatic reset_all();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0;
    idle_inputs();
    model_reset();
    #1;
    n_cmp++;
    if (dut_ctrl() !== 12'b11111_000_0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want %b", dut_ctrl(), 12'b11111_000_0000);
    end
    n_cmp++;
    if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    n_cmp++;
    if (bus.mem_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b want 0", bus.mem_err);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_load_use();
    reset_all();
    set_id(1, 5, 2, 0, 1, 0, 1, 1, 0);          // ld x5, 0(x2)
    tick();
    set_id(1, 6, 5, 1, 1, 1, 1, 0, 0);          // add x6, x5, x1
    #1;
    n_cmp++;
    if (dut_ctrl() !== 12'b00111_010_0000) begin
      n_bad++; $display("FAIL lu_stall: got %b want %b", dut_ctrl(), 12'b00111_010_0000);
    end
    tick();
    n_cmp++;
    if (bus.stall_cnt !== 32'd1) begin
      n_bad++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt);
    end
    #1;
    n_cmp++;
    if (dut_ctrl() !== 12'b11111_000_0000) begin
      n_bad++; $display("FAIL lu_release: got %b want %b", dut_ctrl(), 12'b11111_000_0000);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.fwd_a !== 2'b01 || bus.fwd_b !== 2'b00) begin
      n_bad++; $display("FAIL lu_fwd: got %b/%b want 01/00", bus.fwd_a, bus.fwd_b);
    end
    tick();
  endtask

  task automatic test_forwarding();
    reset_all();
    set_id(1, 3, 0, 0, 0, 0, 1, 0, 0);          // add x3 (older)
    tick();
    tick();                                     // add x3 (younger)
    set_id(1, 9, 3, 7, 1, 1, 1, 0, 0);          // add x9, x3, x7
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b00) begin
      n_bad++; $display("FAIL fwd_mem_wins: got %b/%b want 10/00", bus.fwd_a, bus.fwd_b);
    end
    tick();
    reset_all();
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);          // writes x0
    tick();
    set_id(1, 4, 0, 0, 1, 1, 1, 0, 0);          // reads x0
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
      n_bad++; $display("FAIL fwd_x0: got %b/%b want 00/00", bus.fwd_a, bus.fwd_b);
    end
    tick();
  endtask

  task automatic test_branch_priority();
    reset_all();
    set_id(1, 5, 2, 0, 1, 0, 1, 1, 0);          // ld x5
    tick();
    set_id(1, 6, 5, 1, 1, 1, 1, 0, 0);          // dependent add
    bus.ex_branch_taken = 1;
    #1;
    n_cmp++;
    if (dut_ctrl() !== exp_ctrl() || dut_ctrl() >> 4 !== 12'b0000_1111_1111) begin
      n_bad++; $display("FAIL br_over_lu: got %b want %b", dut_ctrl(), exp_ctrl());
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.flush_cnt !== 32'd1 || bus.stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL br_counts: got flush %0d stall %0d want 1/0", bus.flush_cnt, bus.stall_cnt);
    end
    tick();
  endtask

  task automatic test_freeze_branch();
    reset_all();
    set_id(1, 0, 2, 4, 1, 1, 0, 0, 1);          // sd x4, 0(x2)
    tick();
    set_id(1, 0, 1, 2, 1, 1, 0, 0, 0);          // beq x1, x2
    tick();
    set_id(1, 7, 1, 1, 1, 1, 1, 0, 0);
    bus.ex_branch_taken = 1;
    bus.mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (dut_ctrl() >> 4 !== 12'b0000_0000_0000) begin
        n_bad++; $display("FAIL frz_hold_%0d: got %b want 00000000", c, dut_ctrl() >> 4);
      end
      tick();
    end
    bus.mem_ready = 1;
    #1;
    n_cmp++;
    if (dut_ctrl() >> 4 !== 12'b0000_1111_1111) begin
      n_bad++; $display("FAIL frz_deferred_flush: got %b want 11111111", dut_ctrl() >> 4);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.stall_cnt !== 32'd3 || bus.flush_cnt !== 32'd1) begin
      n_bad++; $display("FAIL frz_counts: got stall %0d flush %0d want 3/1", bus.stall_cnt, bus.flush_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    reset_all();
    set_id(1, 0, 2, 4, 1, 1, 0, 0, 1);          // store
    tick();
    idle_inputs();
    tick();                                     // store now in MEM
    bus.mem_ready = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_cmp++;
      if (bus.mem_err !== ((k >= int'(MEM_TIMEOUT)) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL timeout_k%0d: got %b want %b", k, bus.mem_err, k >= int'(MEM_TIMEOUT));
      end
    end
    bus.mem_ready = 1;
    tick();
    n_cmp++;
    if (bus.mem_err !== 1'b1 || bus.stall_cnt !== 32'd20) begin
      n_bad++; $display("FAIL timeout_sticky: got err %b stall %0d want 1/20", bus.mem_err, bus.stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    reset_all();
    set_id(1, 0, 2, 4, 1, 1, 0, 0, 1);
    tick();
    idle_inputs();
    tick();
    bus.mem_ready = 0;
    repeat (17) tick();
    n_cmp++;
    if (dut.state_q !== ST_MEM_WAIT || bus.mem_err !== 1'b1 || bus.stall_cnt !== 32'd17) begin
      n_bad++; $display("FAIL rm_pre: got st %b err %b stall %0d want 1/1/17", dut.state_q, bus.mem_err, bus.stall_cnt);
    end
    #2;
    reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if (dut.state_q !== ST_RUN || bus.stall_cnt !== '0 || bus.flush_cnt !== '0 || bus.mem_err !== 1'b0) begin
      n_bad++; $display("FAIL rm_state: got st %b stall %0d flush %0d err %b want 0/0/0/0",
                        dut.state_q, bus.stall_cnt, bus.flush_cnt, bus.mem_err);
    end
    n_cmp++;
    if (dut_ctrl() !== 12'b11111_000_0000) begin
      n_bad++; $display("FAIL rm_ctrl: got %b want %b", dut_ctrl(), 12'b11111_000_0000);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1;
  endtask

  task automatic test_random();
    reset_all();
    for (int i = 0; i < 600; i++) begin
      bus.id_valid     = ($urandom % 4) != 0;
      bus.id_rd        = 5'($urandom_range(0, 3));
      bus.id_rs1       = 5'($urandom_range(0, 3));
      bus.id_rs2       = 5'($urandom_range(0, 3));
      bus.id_use_rs1   = 1'($urandom);
      bus.id_use_rs2   = 1'($urandom);
      bus.id_reg_write = 1'($urandom);
      bus.id_mem_read  = ($urandom % 3) == 0;
      bus.id_mem_write = !bus.id_mem_read && (($urandom % 4) == 0);
      bus.ex_branch_taken = ($urandom % 5) == 0;
      bus.mem_ready    = ((i % 150) >= 120) ? 1'b0 : (($urandom % 3) != 0);
      #1;
      n_cmp++;
      if (dut_ctrl() !== exp_ctrl()) begin
        n_bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", i, dut_ctrl(), exp_ctrl());
      end
      n_cmp++;
      if (bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush) || bus.mem_err !== m_err) begin
        n_bad++; $display("FAIL rnd_state@%0d: got %0d/%0d/%b want %0d/%0d/%b", i,
                          bus.stall_cnt, bus.flush_cnt, bus.mem_err, m_stall, m_flush, m_err);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_priority();
    test_freeze_branch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined RV64 core (IF/ID/EX/MEM/WB) built on the existing pc, register_file, alu and data_memory blocks. It keeps its own shadow copy of the register-use information for the EX, MEM and WB stages. From that state it generates:
- pipeline-register enables and flushes;
- forwarding selects for both ALU operands;
- data-memory wait freezes;
- performance counters.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters (saturating).
- MEM_TIMEOUT, 16, maximum consecutive memory-wait cycles before mem_err is set.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register indices.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- id_rd  in  5  ID destination register.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  ID control bits from the control block.
- ex_branch_taken  in  1  branch in EX resolved taken (branch AND z_flag).
- mem_ready  in  1  data memory completes this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables.
- ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID / ID/EX.
- pc_sel_branch  out  1  PC mux selects the branch target.
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.
- mem_err  out  1  sticky memory timeout flag.

Behaviour:
- Shadow state: for each of EX, MEM and WB hold {valid, rd, reg_write, mem_read, mem_write}. EX additionally holds rs1 and rs2. All fields clear to 0 on reset.
- freeze = MEM.valid & (MEM.mem_read | MEM.mem_write) & ~mem_ready.
- branch_flush = ex_branch_taken & EX.valid & ~freeze.
- load_use = ~freeze & ~branch_flush & EX.valid & EX.mem_read & (EX.rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)).
- Priority is freeze > branch_flush > load_use > run.
- Outputs by condition (all combinational from inputs and shadow state):
  - freeze: all five enables 0, no flushes, shadow state held.
  - branch_flush: all enables 1, ifid_flush = idex_flush = 1, pc_sel_branch = 1.
  - load_use: pc_en = ifid_en = 0, idex_flush = 1, the remaining enables 1.
  - run: all enables 1, flushes 0.
- Shadow update when not frozen:
  - WB <= MEM and MEM <= EX.
  - EX <= bubble (valid = 0) if idex_flush is asserted; otherwise EX <= ID fields with valid = id_valid.
  - When frozen, all shadow state holds.
- Forwarding for fwd_a (fwd_b identical using EX.rs2):
  - 10 if MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1;
  - else 01 if the same condition holds for WB;
  - else 00.
  - When both MEM and WB match, MEM wins.
  - x0 never forwards.
- FSM (state encoding in package), states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when freeze = 1.
  - MEM_WAIT -> RUN when mem_ready = 1.
  - A wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When the counter reaches MEM_TIMEOUT, mem_err is set and stays set until reset. The FSM keeps waiting.
- Counters:
  - stall_cnt increments on every cycle with freeze or load_use.
  - flush_cnt increments on every cycle with branch_flush.
  - Both saturate at all-ones.
- Branch held during freeze: flush is deferred. EX holds the branch, so ex_branch_taken is sampled again when freeze drops.
- Reset mid-operation: all state clears immediately (asynchronously), FSM returns to RUN, counters and mem_err clear.
- Reset values of outputs (state cleared): all enables 1, flushes 0, pc_sel_branch 0, fwd 00, counters 0, mem_err 0.

Decomposition:
- Package pipe_ctrl_pkg contains:
  - FWD_RF / FWD_EXMEM / FWD_MEMWB encodings;
  - FSM state encoding;
  - a shadow-stage record type or field-width constants.
- One sub-module, fwd_select: pure comparator producing one 2-bit forwarding select; instantiated twice (operands a and b).

Test Plan:
- ld x5 in EX, ID add x6,x5,x1 (use_rs1) -> one cycle with pc_en = ifid_en = 0 and idex_flush = 1, stall_cnt = 1. Next cycle fwd_a = 01 (value via MEM/WB).
- add x3 in MEM, add x3 in WB, EX.rs1 = 3 -> fwd_a = 10. With MEM.rd = 0 and EX.rs1 = 0 -> fwd_a = 00.
- ex_branch_taken = 1 with EX.valid and a simultaneous load_use condition -> ifid_flush = idex_flush = 1, pc_sel_branch = 1, no stall, flush_cnt = 1.
- Store in MEM with mem_ready low for 3 cycles while ex_branch_taken = 1 -> 3 cycles with all enables 0 and no flush; the flush fires on the cycle mem_ready = 1; stall_cnt = 3.
- mem_ready held low for 20 cycles -> mem_err rises on the 16th wait cycle and stays set after mem_ready returns.
- Assert reset = 0 during MEM_WAIT with nonzero counters -> immediately FSM = RUN, counters 0, mem_err 0, enables 1.
